// File: rtl/sfx_synth.sv
// sfx_synth: multi-channel triggered square-wave tone generator with per-half-cycle pitch sweep,
// summed, saturated and registered into one signed sample on the codec strobe.
module sfx_synth #(
  parameter int               NUM_CH = 4,
  parameter int               PW     = 19,
  parameter int               DW     = 23,
  parameter int               SW     = 8,
  parameter logic signed [23:0] AMP  = 24'sh070000,
  parameter int               MIN_HP = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [NUM_CH-1:0]      trig,
  input  logic [NUM_CH*PW-1:0]   half_period,
  input  logic [NUM_CH*DW-1:0]   duration,
  input  logic [NUM_CH*SW-1:0]   sweep,
  output logic [NUM_CH-1:0]      busy,
  output logic signed [23:0]     note
);
  localparam int MW = 24 + $clog2(NUM_CH) + 1;
  localparam logic signed [PW+1:0] HP_MIN = (PW+2)'(MIN_HP);
  localparam logic signed [PW+1:0] HP_MAX = (PW+2)'((2**PW) - 1);
  localparam logic signed [MW-1:0] AMP_X  = MW'(AMP);
  localparam logic signed [MW-1:0] SAT_HI = MW'(24'sh7FFFFF);
  localparam logic signed [MW-1:0] SAT_LO = MW'(24'sh800000);
  typedef enum logic {IDLE, PLAY} state_t;
  state_t              r_state   [NUM_CH];
  state_t              w_state_nx[NUM_CH];
  logic [PW-1:0]       r_hp      [NUM_CH];
  logic [PW-1:0]       w_hp_nx   [NUM_CH];
  logic [PW-1:0]       r_pcnt    [NUM_CH];
  logic [PW-1:0]       w_pcnt_nx [NUM_CH];
  logic [DW-1:0]       r_dcnt    [NUM_CH];
  logic [DW-1:0]       w_dcnt_nx [NUM_CH];
  logic [SW-1:0]       r_stp     [NUM_CH];
  logic [SW-1:0]       w_stp_nx  [NUM_CH];
  logic                r_pol     [NUM_CH];
  logic                w_pol_nx  [NUM_CH];
  logic signed [PW+1:0] w_hp_sum [NUM_CH];
  logic [PW-1:0]       w_hp_cl   [NUM_CH];
  logic [NUM_CH-1:0]   r_trig_d;
  logic [NUM_CH-1:0]   w_start;
  logic signed [MW-1:0] w_sum;
  logic signed [23:0]  w_sat;
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_start[i]    = trig[i] & ~r_trig_d[i] & (|half_period[i*PW +: PW]) & (|duration[i*DW +: DW]);
      // two guard bits keep hp + step from wrapping before the clamp
      w_hp_sum[i]   = $signed({2'b00, r_hp[i]}) + $signed({{(PW+2-SW){r_stp[i][SW-1]}}, r_stp[i]});
      w_hp_cl[i]    = w_hp_sum[i] < HP_MIN ? HP_MIN[PW-1:0] :
                      w_hp_sum[i] > HP_MAX ? HP_MAX[PW-1:0] : w_hp_sum[i][PW-1:0];
      w_state_nx[i] = r_state[i];
      w_hp_nx[i]    = r_hp[i];
      w_pcnt_nx[i]  = r_pcnt[i];
      w_dcnt_nx[i]  = r_dcnt[i];
      w_stp_nx[i]   = r_stp[i];
      w_pol_nx[i]   = r_pol[i];
      if (w_start[i]) begin
        w_state_nx[i] = PLAY;
        w_hp_nx[i]    = half_period[i*PW +: PW];
        w_pcnt_nx[i]  = half_period[i*PW +: PW] - PW'(1);
        w_dcnt_nx[i]  = duration[i*DW +: DW] - DW'(1);
        w_stp_nx[i]   = sweep[i*SW +: SW];
        w_pol_nx[i]   = 1'b0;
      end else if (r_state[i] == PLAY) begin
        w_hp_nx[i]    = r_pcnt[i] == '0 ? w_hp_cl[i] : r_hp[i];
        w_pcnt_nx[i]  = r_pcnt[i] == '0 ? w_hp_cl[i] - PW'(1) : r_pcnt[i] - PW'(1);
        w_pol_nx[i]   = r_pol[i] ^ (r_pcnt[i] == '0);
        w_dcnt_nx[i]  = r_dcnt[i] - DW'(1);
        w_state_nx[i] = r_dcnt[i] == '0 ? IDLE : PLAY;
      end
      busy[i] = r_state[i] == PLAY;
      w_sum   = w_sum + (r_state[i] != PLAY ? MW'(0) : r_pol[i] ? -AMP_X : AMP_X);
    end
    w_sat = w_sum > SAT_HI ? 24'sh7FFFFF : w_sum < SAT_LO ? 24'sh800000 : w_sum[23:0];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_trig_d <= '0;
      note     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= IDLE;
        r_hp[i]    <= '0;
        r_pcnt[i]  <= '0;
        r_dcnt[i]  <= '0;
        r_stp[i]   <= '0;
        r_pol[i]   <= 1'b0;
      end
    end else begin
      r_trig_d <= trig;
      if (en) note <= w_sat;
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= w_state_nx[i];
        r_hp[i]    <= w_hp_nx[i];
        r_pcnt[i]  <= w_pcnt_nx[i];
        r_dcnt[i]  <= w_dcnt_nx[i];
        r_stp[i]   <= w_stp_nx[i];
        r_pol[i]   <= w_pol_nx[i];
      end
    end
  end
endmodule
